// File: rtl/tinyqv_instr_aligner.sv
// Instruction aligner: turns a stream of fetch beats into aligned 16/32-bit RISC-V instructions.
// A circular halfword buffer hides 32-bit instructions straddling beat boundaries.
module tinyqv_instr_aligner #(
  parameter int                   HW_PER_BEAT = 2,
  parameter int                   DEPTH       = 4,
  parameter int                   ADDR_BITS   = 24,
  parameter logic [ADDR_BITS-1:0] RESET_PC    = '0
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic [16*HW_PER_BEAT-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_flush,
  input  logic [ADDR_BITS-1:0]      in_flush_pc,

  output logic [31:0]               out_instr,
  output logic [1:0]                out_len,
  output logic [ADDR_BITS-1:0]      out_pc,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]          mem [DEPTH];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [CW-1:0]        count;
  logic                 skip;
  logic [ADDR_BITS-1:0] pc;

  logic [15:0]          h0;
  logic [15:0]          h1;
  logic                 head_is_32;
  logic                 push;
  logic                 pop;
  logic [CW-1:0]        push_n;
  logic [CW-1:0]        pop_n;
  logic [CW-1:0]        free_n;
  logic                 skip_on_flush;
  logic                 unused_flush_pc_lsb;

  assign unused_flush_pc_lsb = in_flush_pc[0];

  // Head view: h1 is taken across the pointer wrap by the natural PW-bit overflow.
  assign h0         = mem[rd_ptr];
  assign h1         = mem[rd_ptr + PW'(1)];
  assign head_is_32 = (h0[1:0] == 2'b11);

  assign free_n   = CW'(DEPTH) - count;
  assign in_ready = (free_n >= CW'(HW_PER_BEAT));

  always_comb begin
    out_valid = 1'b0;
    out_len   = 2'b01;
    out_instr = {16'h0000, h0};
    if (head_is_32) begin
      out_len   = 2'b10;
      out_instr = {h1, h0};
      out_valid = !in_flush && (count >= CW'(2));
    end else begin
      out_valid = !in_flush && (count != '0);
    end
  end

  assign out_pc = pc;

  assign push = in_valid && in_ready && !in_flush;
  assign pop  = out_valid && out_ready;

  // A pending skip drops the low halfword of the first beat after a flush.
  always_comb begin
    push_n = '0;
    if (push) begin
      push_n = skip ? CW'(HW_PER_BEAT - 1) : CW'(HW_PER_BEAT);
    end
  end

  always_comb begin
    pop_n = '0;
    if (pop) begin
      pop_n = head_is_32 ? CW'(2) : CW'(1);
    end
  end

  assign skip_on_flush = (HW_PER_BEAT == 2) && in_flush_pc[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      skip   <= 1'b0;
      pc     <= RESET_PC;
    end else if (in_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      skip   <= skip_on_flush;
      pc     <= {in_flush_pc[ADDR_BITS-1:1], 1'b0};
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(pop_n);
        pc     <= pc + ADDR_BITS'({pop_n, 1'b0});
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(push_n);
        skip   <= 1'b0;
      end
      count <= count + push_n - pop_n;
    end
  end

  // Storage needs no reset: count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      for (int i = 0; i < HW_PER_BEAT; i++) begin
        if (!(skip && (i == 0))) begin
          mem[wr_ptr + PW'(i) - PW'(skip)] <= in_data[16*i +: 16];
        end
      end
    end
  end

endmodule

// File: tb/tb_tinyqv_instr_aligner.sv
// Self-checking bench for tinyqv_instr_aligner: directed scenarios plus random traffic,
// all checked against a halfword-queue reference model.
module tb_tinyqv_instr_aligner;

  localparam int             HW    = 2;
  localparam int             DEPTH = 4;
  localparam int             AB    = 24;
  localparam logic [AB-1:0]  RPC   = 24'hFFFFFE;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic          in_flush;
  logic [AB-1:0] in_flush_pc;
  logic [31:0]   out_instr;
  logic [1:0]    out_len;
  logic [AB-1:0] out_pc;
  logic          out_valid;
  logic          out_ready;

  always #5 clk = ~clk;

  tinyqv_instr_aligner #(
    .HW_PER_BEAT(HW),
    .DEPTH      (DEPTH),
    .ADDR_BITS  (AB),
    .RESET_PC   (RPC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_flush   (in_flush),
    .in_flush_pc(in_flush_pc),
    .out_instr  (out_instr),
    .out_len    (out_len),
    .out_pc     (out_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model: the buffered halfwords in program order
  logic [15:0]   q[$];
  logic [AB-1:0] m_pc;
  bit            m_skip;
  bit            m_ok = 1'b0;

  logic          obs_valid;
  logic          obs_ready;
  logic [31:0]   obs_instr;
  logic [1:0]    obs_len;
  logic [AB-1:0] obs_pc;
  logic [2:0]    obs_count;
  logic          obs_skip;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [31:0] d,
                      input bit f, input logic [AB-1:0] fp, input bit rdy);
    bit          e_valid;
    bit          e_ready;
    bit          is32;
    logic [31:0] e_instr;
    rst = r; in_valid = v; in_data = d; in_flush = f; in_flush_pc = fp; out_ready = rdy;
    #1;
    obs_valid = out_valid; obs_ready = in_ready; obs_instr = out_instr;
    obs_len   = out_len;   obs_pc    = out_pc;   obs_count = dut.count; obs_skip = dut.skip;

    e_ready = (DEPTH - q.size()) >= HW;
    is32    = (q.size() > 0) && (q[0][1:0] == 2'b11);
    e_valid = !f && (q.size() >= (is32 ? 2 : 1));
    e_instr = 32'h0;
    if (e_valid) e_instr = is32 ? {q[1], q[0]} : {16'h0000, q[0]};

    if (m_ok) begin
      check("in_ready",  obs_ready, e_ready);
      check("out_valid", obs_valid, e_valid);
      check("out_pc",    obs_pc,    m_pc);
      check("count",     obs_count, q.size());
      if (e_valid) begin
        check("out_instr", obs_instr, e_instr);
        check("out_len",   obs_len,   is32 ? 2'b10 : 2'b01);
      end
    end

    if (r) begin
      q.delete(); m_pc = RPC; m_skip = 1'b0; m_ok = 1'b1;
    end else if (f) begin
      q.delete(); m_pc = {fp[AB-1:1], 1'b0}; m_skip = (HW == 2) && fp[1];
    end else begin
      if (e_valid && rdy) begin
        repeat (is32 ? 2 : 1) void'(q.pop_front());
        m_pc = m_pc + AB'(is32 ? 4 : 2);
      end
      if (v && e_ready) begin
        for (int i = 0; i < HW; i++)
          if (!(m_skip && i == 0)) q.push_back(d[16*i +: 16]);
        m_skip = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_flush = 1'b0; in_flush_pc = '0; out_ready = 1'b0;
    @(negedge clk);

    // reset, then reset overriding a beat and a flush
    step(1, 0, 32'h0, 0, 24'h0, 0);
    step(1, 1, 32'h11111111, 1, 24'h000010, 1);
    step(0, 0, 32'h0, 0, 24'h0, 0);
    check("rst_valid", obs_valid, 1'b0);
    check("rst_ready", obs_ready, 1'b1);
    check("rst_pc",    obs_pc,    RPC);
    check("rst_count", obs_count, 3'd0);

    // PC wrap on a 32-bit pop from RESET_PC
    step(0, 1, 32'hABCD0003, 0, 24'h0, 0);
    step(0, 0, 32'h0, 0, 24'h0, 1);
    check("pcw_instr", obs_instr, 32'hABCD0003);
    check("pcw_pc",    obs_pc,    RPC);
    step(0, 0, 32'h0, 0, 24'h0, 0);
    check("pcw_after", obs_pc, 24'h000002);

    // mixed stream
    step(0, 0, 32'h0, 1, 24'h0, 0);
    step(0, 1, 32'h00130001, 0, 24'h0, 1);
    step(0, 1, 32'h00000513, 0, 24'h0, 1);
    check("mix0_instr", obs_instr, 32'h00000001);
    check("mix0_len",   obs_len,   2'b01);
    check("mix0_pc",    obs_pc,    24'h0);
    step(0, 0, 32'h0, 0, 24'h0, 1);
    check("mix1_instr", obs_instr, 32'h05130013);
    check("mix1_len",   obs_len,   2'b10);
    check("mix1_pc",    obs_pc,    24'h2);
    step(0, 0, 32'h0, 0, 24'h0, 0);
    check("mix_count",  obs_count, 3'd1);

    // 32-bit instruction in entries 3 and 0, straddling two beats
    step(0, 0, 32'h0, 1, 24'h0, 0);
    step(0, 1, 32'h00050001, 0, 24'h0, 0);
    step(0, 0, 32'h0, 0, 24'h0, 1);
    step(0, 0, 32'h0, 0, 24'h0, 1);
    step(0, 1, 32'h12330011, 0, 24'h0, 0);
    step(0, 0, 32'h0, 0, 24'h0, 1);
    step(0, 1, 32'h0021ABCD, 0, 24'h0, 0);
    check("wrap_straddle", obs_valid, 1'b0);
    check("wrap_cnt1",     obs_count, 3'd1);
    step(0, 0, 32'h0, 0, 24'h0, 1);
    check("wrap_instr", obs_instr, 32'hABCD1233);
    check("wrap_len",   obs_len,   2'b10);
    check("wrap_pc",    obs_pc,    24'h6);
    step(0, 0, 32'h0, 0, 24'h0, 0);
    check("wrap_after_cnt", obs_count, 3'd1);
    check("wrap_after_pc",  obs_pc,    24'hA);
    check("wrap_next",      obs_instr, 32'h00000021);

    // flush to an odd halfword with 3 halfwords buffered
    step(0, 0, 32'h0, 1, 24'h0, 0);
    step(0, 1, 32'h00050001, 0, 24'h0, 0);
    step(0, 1, 32'h00090007, 0, 24'h0, 1);
    step(0, 1, 32'hDEADBEEF, 1, 24'h000102, 1);
    check("fl_valid", obs_valid, 1'b0);
    check("fl_cnt3",  obs_count, 3'd3);
    step(0, 1, 32'h12340001, 0, 24'h0, 0);
    step(0, 0, 32'h0, 0, 24'h0, 1);
    check("fl_instr", obs_instr, 32'h00001234);
    check("fl_pc",    obs_pc,    24'h000102);
    check("fl_ovld",  obs_valid, 1'b1);
    step(0, 0, 32'h0, 0, 24'h0, 0);
    check("fl_drop",  obs_count, 3'd0);

    // a second flush recomputes the skip flag
    step(0, 0, 32'h0, 1, 24'h000102, 0);
    step(0, 0, 32'h0, 1, 24'h000100, 0);
    step(0, 1, 32'h00050001, 0, 24'h0, 0);
    step(0, 0, 32'h0, 0, 24'h0, 1);
    check("reskip_instr", obs_instr, 32'h00000001);
    check("reskip_pc",    obs_pc,    24'h000100);

    // back-pressure then drain
    step(0, 0, 32'h0, 1, 24'h0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, $urandom, 0, 24'h0, 0);
      if (i == 2) check("bp_ready_drop", obs_ready, 1'b0);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 32'h0, 0, 24'h0, 1);

    // push + pop + flush together, then reset together with flush
    step(0, 0, 32'h0, 1, 24'h0, 0);
    step(0, 1, 32'h00050001, 0, 24'h0, 0);
    step(0, 1, 32'h00090001, 1, 24'h000202, 1);
    check("sim_valid", obs_valid, 1'b0);
    step(1, 1, 32'h00000001, 1, 24'h000404, 1);
    check("sim_fl_pc",   obs_pc,    24'h000202);
    check("sim_fl_cnt",  obs_count, 3'd0);
    check("sim_fl_skip", obs_skip,  1'b1);
    step(0, 0, 32'h0, 0, 24'h0, 0);
    check("sim_rst_pc",    obs_pc,    RPC);
    check("sim_rst_cnt",   obs_count, 3'd0);
    check("sim_rst_skip",  obs_skip,  1'b0);
    check("sim_rst_ready", obs_ready, 1'b1);
    check("sim_rst_valid", obs_valid, 1'b0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70, $urandom,
           $urandom_range(0, 99) < 6, AB'($urandom), $urandom_range(0, 99) < 60);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tinyqv_instr_aligner.md
TINYQV_INSTR_ALIGNER -- requirements
Module: tinyqv_instr_aligner

Interface
REQ-001 The block SHALL have these parameters: HW_PER_BEAT, default 2, halfwords per fetch beat (1 or 2); DEPTH, default 4, halfword buffer entries (power of 2, at least 2*HW_PER_BEAT); ADDR_BITS, default 24, byte PC width; RESET_PC, default 0, PC loaded at reset (bit 0 zero).
REQ-002 The block SHALL have these ports:
- clk  in  1  clock; one clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_data  in  16*HW_PER_BEAT  fetch beat; halfword 0 is in bits [15:0] and is the lowest address.
- in_valid  in  1  fetch beat present.
- in_ready  out  1  buffer can accept a full beat.
- in_flush  in  1  redirect; discards all buffered and in-flight data.
- in_flush_pc  in  ADDR_BITS  new PC on flush; bit 0 is ignored.
- out_instr  out  32  aligned instruction.
- out_len  out  2  instruction length in halfwords: 2'b01 is 16-bit, 2'b10 is 32-bit.
- out_pc  out  ADDR_BITS  byte address of out_instr.
- out_valid  out  1  out_instr is complete.
- out_ready  in  1  consumer takes the instruction.

Function
REQ-003 The block SHALL hold a circular halfword buffer of DEPTH entries with read pointer, write pointer and count (0..DEPTH); pointers wrap modulo DEPTH.
REQ-004 in_ready SHALL be 1 iff (DEPTH - count) >= HW_PER_BEAT, from registered state only.
REQ-005 A beat is accepted when in_valid && in_ready && !in_flush; its halfwords are written in ascending order starting at the write pointer.
REQ-006 Accepted data SHALL first be visible on out_* one cycle after acceptance; there is no combinational path from in_data/in_valid to out_*.
REQ-007 Head halfword h0 with h0[1:0] != 2'b11: out_valid = (count >= 1), out_len = 2'b01, out_instr = {16'h0000, h0}.
REQ-008 Head halfword h0 with h0[1:0] == 2'b11: out_valid = (count >= 2), out_len = 2'b10, out_instr = {h1, h0}, where h1 is the next entry, taken across the pointer wrap.
REQ-009 A 32-bit head with count == 1 (straddling beats) SHALL hold out_valid at 0 until the second halfword arrives.
REQ-010 When out_valid && out_ready && !in_flush, the block SHALL pop out_len halfwords and advance out_pc by 2*out_len, modulo 2^ADDR_BITS.
REQ-011 Push and pop in the same cycle SHALL both take effect; the new count is count + pushed - popped.
REQ-012 out_valid SHALL be 0 in any cycle where in_flush = 1.
REQ-013 in_flush SHALL take priority over push and pop in the same cycle. The block SHALL clear count and pointers and load out_pc = {in_flush_pc[ADDR_BITS-1:1], 1'b0}.
REQ-014 If HW_PER_BEAT = 2 and in_flush_pc[1] = 1, the block SHALL set a skip flag. The low halfword of the first beat accepted after the flush SHALL be discarded, only the high halfword is written, and the skip flag clears.
REQ-015 A further flush while the skip flag is set SHALL recompute the flag from the new in_flush_pc.
REQ-016 out_instr and out_len are don't-care while out_valid = 0.

Reset
REQ-017 While rst = 1, on each clock: count = 0, pointers = 0, skip flag = 0, out_pc = RESET_PC; after the edge out_valid = 0 and in_ready = 1.
REQ-018 rst SHALL override in_flush and any handshake in the same cycle. A beat presented during reset is not accepted.
REQ-019 Reset asserted mid-operation SHALL discard all buffered halfwords, including an incomplete 32-bit instruction.

Verification
REQ-020 Mixed stream: HW_PER_BEAT = 2, beats 0x00130001 then 0x00000513, out_ready = 1. Required outputs:
- {0x00000001, len 01, pc 0}
- {0x05130013, len 10, pc 2}
- then out_valid = 0 with count 1.
REQ-021 Back-pressure: out_ready = 0, valid beats offered every cycle. in_ready drops to 0 when count > DEPTH-2. No beat is lost. Draining afterwards yields every instruction in order with the correct out_pc.
REQ-022 Flush to odd halfword: in_flush_pc = 0x000102 with 3 halfwords buffered, then beat 0x12340001. Required: out_valid = 0 in the flush cycle; the next output is {0x00001234, pc 0x000102}; 0x0001 is discarded.
REQ-023 Pointer wrap: DEPTH = 4, a 32-bit instruction placed in entries 3 and 0. Required: out_instr = {entry0, entry3}; count and pc correct after the pop.
REQ-024 Simultaneous events: push, pop and in_flush in one cycle, then rst together with in_flush. Required: flush state wins in the first cycle; reset values per REQ-017 win in the second.
REQ-025 PC wrap: RESET_PC = 2^ADDR_BITS - 2 with a 32-bit instruction popped. Required: out_pc = 2 after the pop.
